// File: rtl/asg_frame_scheduler.sv
// Double-buffered frame loader: assembles a stream of words into a shadow frame
// and swaps it into the active DATA vector on each radar trigger.
module asg_frame_scheduler #(
  parameter int SIZE   = 3200,
  parameter int WORD_W = 32
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RESETN,
  input  logic              EN,
  input  logic              RADAR_TRIG_PE,
  input  logic [WORD_W-1:0] S_TDATA,
  input  logic              S_TVALID,
  input  logic              S_TLAST,
  output logic              S_TREADY,
  output logic [SIZE-1:0]   DATA,
  output logic              GEN_EN,
  output logic              GEN_TRIG,
  output logic [15:0]       FRAME_CNT,
  output logic              UNDERRUN,
  output logic              FRAME_ERR
);

  localparam int NWORDS = (SIZE + WORD_W - 1) / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BIT_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, READY} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SIZE-1:0]   shadow;
  logic [BIT_W-1:0]  word_base;
  logic              accept;
  logic              swap;
  logic              underrun_d;
  logic              frame_err_d;
  logic              clear;

  assign S_TREADY  = (state_q == FILL);
  assign accept    = S_TREADY & S_TVALID;
  assign word_base = BIT_W'(idx_q) * BIT_W'(WORD_W);

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    swap        = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    clear       = 1'b0;
    if (!EN) begin
      state_d = IDLE;
      idx_d   = '0;
      clear   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FILL;
          idx_d   = '0;
        end
        FILL: begin
          // A trigger here is an underrun even if this beat completes the frame.
          underrun_d = RADAR_TRIG_PE;
          if (accept) begin
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              if (S_TLAST) state_d = READY;
              else         frame_err_d = 1'b1;
            end else if (S_TLAST) begin
              idx_d       = '0;
              frame_err_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        READY: begin
          if (RADAR_TRIG_PE) begin
            swap    = 1'b1;
            state_d = FILL;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RESETN) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the shadow buffer is a wide register, not a RAM, so it is reset
  // and cleared like any other state.
  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RESETN) begin
      shadow    <= '0;
      DATA      <= '0;
      GEN_EN    <= 1'b0;
      GEN_TRIG  <= 1'b0;
      FRAME_CNT <= '0;
      UNDERRUN  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      GEN_TRIG  <= 1'b0;
      UNDERRUN  <= underrun_d;
      FRAME_ERR <= frame_err_d;

      if (clear) begin
        shadow <= '0;
      end else if (accept) begin
        // Bits of the final word beyond SIZE have no home and are dropped.
        for (int j = 0; j < WORD_W; j++) begin
          if (int'(word_base) + j < SIZE) shadow[word_base + BIT_W'(j)] <= S_TDATA[j];
        end
      end

      if (!EN) begin
        GEN_EN <= 1'b0;
      end else if (swap) begin
        DATA      <= shadow;
        GEN_EN    <= 1'b1;
        GEN_TRIG  <= 1'b1;
        FRAME_CNT <= FRAME_CNT + 16'd1;
      end else if (underrun_d) begin
        // Restart the generator anyway, but blank it until a frame is ready.
        GEN_EN   <= 1'b0;
        GEN_TRIG <= 1'b1;
      end
    end
  end

endmodule
